// File: rtl/icache_refill_pkg.sv
// Shared types and sizing helpers for the instruction-cache refill scheduler.
// Provides the tag width, the outstanding-counter width and the arbiter FSM states.
package icache_refill_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // A single requester still needs one tag bit.
  function automatic int log_n(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/icache_rr_pick.sv
// Combinational round-robin picker: the first eligible index at or after ptr_i,
// wrapping at N. The index range need not be a power of two.
module icache_rr_pick
  import icache_refill_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = log_n(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] sel_o,
  output logic          any_valid_o
);

  int idx;

  // Walk the distances from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    sel_o       = '0;
    any_valid_o = |elig_i;
    idx         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (elig_i[idx]) begin
        sel_o = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/icache_refill_scheduler.sv
// Shares one L2 refill port among N_MASTER miss requesters: round-robin issue,
// request held stable until granted, in-flight cap, tag-routed responses.
module icache_refill_scheduler
  import icache_refill_pkg::*;
#(
  parameter  int N_MASTER        = 4,
  parameter  int ADDR_WIDTH      = 32,
  parameter  int DATA_WIDTH      = 128,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int LOG_N           = log_n(N_MASTER)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_MASTER-1:0]                 req_i,
  input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] add_i,
  output logic [N_MASTER-1:0]                 gnt_o,
  output logic [N_MASTER-1:0]                 r_valid_o,
  output logic [DATA_WIDTH-1:0]               r_rdata_o,
  output logic                                mem_req_o,
  output logic [ADDR_WIDTH-1:0]               mem_add_o,
  output logic [LOG_N-1:0]                    mem_ID_o,
  input  logic                                mem_gnt_i,
  input  logic                                mem_r_valid_i,
  input  logic [LOG_N-1:0]                    mem_r_ID_i,
  input  logic [DATA_WIDTH-1:0]               mem_r_rdata_i,
  output logic                                err_o
);

  localparam int            CW      = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N_MASTER - 1);

  state_e                  state_q, state_d;
  logic [LOG_N-1:0]        rr_ptr_q, rr_ptr_d;
  logic [N_MASTER-1:0]     pending_q, pending_d;
  logic [CW-1:0]           out_cnt_q, out_cnt_d;
  logic                    err_q, err_d;
  logic [LOG_N-1:0]        hold_idx_q, hold_idx_d;
  logic [ADDR_WIDTH-1:0]   hold_add_q, hold_add_d;

  logic [N_MASTER-1:0]     eligible;
  logic                    blocked;
  logic [LOG_N-1:0]        pick_sel;
  logic                    pick_any;
  logic                    issue;
  logic [LOG_N-1:0]        issue_idx;
  logic                    handshake;
  logic                    resp_hit;
  logic                    resp_bad;

  assign eligible = req_i & ~pending_q;
  assign blocked  = (out_cnt_q == MAX_CNT);

  icache_rr_pick #(
    .N  (N_MASTER),
    .PW (LOG_N)
  ) u_rr_pick (
    .elig_i      (eligible),
    .ptr_i       (rr_ptr_q),
    .sel_o       (pick_sel),
    .any_valid_o (pick_any)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:     if (issue && !mem_gnt_i) state_d = HOLD;
      HOLD:    if (mem_gnt_i)           state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Issue outputs; qualified by rst_n so nothing is presented while reset is asserted.
  always_comb begin
    issue     = 1'b0;
    issue_idx = '0;
    mem_add_o = '0;
    if (rst_n) begin
      unique case (state_q)
        HOLD: begin
          issue     = 1'b1;
          issue_idx = hold_idx_q;
          mem_add_o = hold_add_q;
        end
        default: begin
          if (!blocked && pick_any) begin
            issue     = 1'b1;
            issue_idx = pick_sel;
            mem_add_o = add_i[pick_sel];
          end
        end
      endcase
    end
  end

  assign mem_req_o = issue;
  assign mem_ID_o  = issue_idx;
  assign handshake = issue & mem_gnt_i;
  assign r_rdata_o = mem_r_rdata_i;

  // Per-requester grant and response decode; a tag beyond N_MASTER-1 matches nobody.
  for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_port
    assign gnt_o[gi]     = handshake && (issue_idx == LOG_N'(gi));
    assign r_valid_o[gi] = mem_r_valid_i && (mem_r_ID_i == LOG_N'(gi)) && pending_q[gi];
  end

  assign resp_hit = |r_valid_o;
  assign resp_bad = mem_r_valid_i & ~resp_hit;

  always_comb begin
    hold_idx_d = hold_idx_q;
    hold_add_d = hold_add_q;
    if (state_q == ARB && issue && !mem_gnt_i) begin
      hold_idx_d = issue_idx;
      hold_add_d = mem_add_o;
    end

    rr_ptr_d = rr_ptr_q;
    if (handshake) begin
      rr_ptr_d = (issue_idx == LAST_IDX) ? '0 : issue_idx + LOG_N'(1);
    end

    // A granted requester is never pending, so clear-then-set cannot collide.
    pending_d = (pending_q & ~r_valid_o) | gnt_o;

    out_cnt_d = out_cnt_q;
    if (handshake && !resp_hit) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end else if (!handshake && resp_hit) begin
      out_cnt_d = out_cnt_q - CW'(1);
    end

    err_d = err_q | resp_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      pending_q  <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
      hold_idx_q <= '0;
      hold_add_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      pending_q  <= pending_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_d;
      hold_idx_q <= hold_idx_d;
      hold_add_q <= hold_add_d;
    end
  end

  assign err_o = err_q;

endmodule
